capture_readout: RTL and testbench

- Reader side of the capture FIFO: drains samples the sampler wrote and streams them to the host through the UART transmitter.
- Starts on a one-cycle `start` pulse, normally from the command decoder once `run` has completed.
- Frames every dump as: header 0xA5, 16-bit sample count (MSB first), sample bytes, then a trailer byte.
- Sits between the capture FIFO read port and the UART_com transmit interface (`trans_en` / `data_out`).

---
 rtl/analyzer_pkg.sv | 44 ++++
 rtl/uart_byte_issuer.sv | 70 +++++++
 rtl/capture_readout.sv | 204 ++++++++++++++++++++
 tb/tb_capture_readout.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/analyzer_pkg.sv
// Shared definitions for the logic-analyzer capture path.
//
// Contents:
//   SAMPLE_WIDTH     default width of one captured sample
//   HDR_BYTE         first byte of every readout frame
//   TRL_OK           trailer for a frame that sent every requested sample
//   TRL_UNDER        trailer for a frame cut short by an empty FIFO
//   readout_state_t  state encoding of the capture_readout sequencer
//   issuer_state_t   state encoding of the UART byte issuer
//   idx_width()      width of a byte index for a given bytes-per-sample

package analyzer_pkg;

  localparam int SAMPLE_WIDTH = 8;

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam logic [7:0] TRL_OK    = 8'h5A;
  localparam logic [7:0] TRL_UNDER = 8'h5E;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    HDR     = 4'd1,
    CNT_HI  = 4'd2,
    CNT_LO  = 4'd3,
    FETCH   = 4'd4,
    WAIT_RD = 4'd5,
    SEND    = 4'd6,
    TRAIL   = 4'd7,
    DONE    = 4'd8
  } readout_state_t;

  typedef enum logic [1:0] {
    ISS_IDLE  = 2'd0,
    ISS_GUARD = 2'd1,
    ISS_WAIT  = 2'd2
  } issuer_state_t;

  // A single-byte sample still needs a 1-bit index so the select logic
  // has a real signal to work with.
  function automatic int idx_width(input int bps);
    return (bps <= 1) ? 1 : $clog2(bps);
  endfunction

endpackage

// File: rtl/uart_byte_issuer.sv
// UART transmit handshake for one byte at a time.
//
// Handshake (valid/ready style): the sequencer holds req high with the byte
// on byte_in for as long as it wants that byte sent. The issuer launches it
// with a one-cycle tx_start once tx_busy is low, ignores tx_busy for the
// following guard cycle (the transmitter needs a cycle to raise it), then
// waits for tx_busy to fall and reports completion with a one-cycle
// byte_accepted. The cycle carrying byte_accepted never launches, so the
// sequencer can swap to its next byte before the issuer looks at req again.
// Consecutive tx_start pulses are therefore at least four cycles apart.
//
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   req            sequencer wants byte_in transmitted
//   byte_in        byte to transmit, sampled on launch
//   tx_busy        transmitter busy flag
//   tx_start       one-cycle launch strobe to the transmitter
//   tx_data        launched byte, held until the next launch
//   byte_accepted  one-cycle pulse: transmitter finished the launched byte
//   state_dbg      current issuer state

module uart_byte_issuer
  import analyzer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] byte_in,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       byte_accepted,
  output logic [1:0] state_dbg
);

  issuer_state_t state;

  assign state_dbg = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ISS_IDLE;
      tx_start      <= 1'b0;
      tx_data       <= 8'h00;
      byte_accepted <= 1'b0;
    end else begin
      tx_start      <= 1'b0;
      byte_accepted <= 1'b0;
      case (state)
        ISS_IDLE: begin
          if (req && !tx_busy && !byte_accepted) begin
            tx_start <= 1'b1;
            tx_data  <= byte_in;
            state    <= ISS_GUARD;
          end
        end
        // tx_busy may still be low here even though the byte was taken.
        ISS_GUARD: state <= ISS_WAIT;
        ISS_WAIT: begin
          if (!tx_busy) begin
            byte_accepted <= 1'b1;
            state         <= ISS_IDLE;
          end
        end
        default: state <= ISS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/capture_readout.sv
// Reader side of the capture FIFO. On a start pulse it streams one frame to
// the UART transmitter:
//   HDR_BYTE, count[15:8], count[7:0], sample bytes (MSB byte first), trailer
// The trailer is TRL_OK when every requested sample was sent, or TRL_UNDER
// when the FIFO ran dry first (underrun is then flagged until the next
// accepted start).
//
// Ports:
//   clock, reset     clock and asynchronous active-high reset
//   start            one-cycle pulse starting a dump; ignored while busy
//   sample_count     samples to send, latched on start
//   fifo_empty       capture FIFO empty flag
//   fifo_rd_data     FIFO read data, valid the cycle after the pop
//   fifo_rd_en       one-cycle FIFO pop strobe
//   tx_busy          UART transmitter busy
//   tx_start         one-cycle UART send strobe
//   tx_data          byte for the UART, held between strobes
//   busy             a dump is in progress
//   done             one-cycle pulse once the trailer is handed to the UART
//   underrun         sticky FIFO-underrun flag
//   state_dbg        sequencer state
//   issuer_state_dbg byte issuer state

module capture_readout
  import analyzer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = analyzer_pkg::SAMPLE_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             sample_count,
  input  logic                    fifo_empty,
  input  logic [SAMPLE_WIDTH-1:0] fifo_rd_data,
  output logic                    fifo_rd_en,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic                    busy,
  output logic                    done,
  output logic                    underrun,
  output logic [3:0]              state_dbg,
  output logic [1:0]              issuer_state_dbg
);

  localparam int BPS = (SAMPLE_WIDTH + 7) / 8;
  localparam int IW  = idx_width(BPS);
  localparam int SRW = BPS * 8;

  readout_state_t  state;
  logic [15:0]     remaining;
  logic [15:0]     count_reg;
  logic [SRW-1:0]  sample_reg;
  logic [IW-1:0]   idx;
  logic [7:0]      trailer;
  logic            sent;      // current byte has been launched
  logic            rd_phase;  // second WAIT_RD cycle: read data is valid

  logic            iss_req;
  logic [7:0]      iss_byte;
  logic [7:0]      cur_byte;
  logic            byte_accepted;

  assign state_dbg = state;

  uart_byte_issuer u_issuer (
    .clock         (clock),
    .reset         (reset),
    .req           (iss_req),
    .byte_in       (iss_byte),
    .tx_busy       (tx_busy),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .byte_accepted (byte_accepted),
    .state_dbg     (issuer_state_dbg)
  );

  // Byte of the sample register selected by idx.
  always_comb begin
    cur_byte = sample_reg[7:0];
    for (int i = 0; i < BPS; i++) begin
      if (idx == IW'(i)) cur_byte = sample_reg[i*8 +: 8];
    end
  end

  // Request to the issuer. In IDLE a start pulse already requests the
  // header so the first tx_start follows start by a single cycle.
  always_comb begin
    iss_req  = 1'b0;
    iss_byte = HDR_BYTE;
    case (state)
      IDLE:   iss_req = start;
      HDR:    iss_req = 1'b1;
      CNT_HI: begin iss_req = 1'b1; iss_byte = count_reg[15:8]; end
      CNT_LO: begin iss_req = 1'b1; iss_byte = count_reg[7:0];  end
      SEND:   begin iss_req = 1'b1; iss_byte = cur_byte;        end
      TRAIL:  begin iss_req = 1'b1; iss_byte = trailer;         end
      default: ;
    endcase
  end

  // A byte counts as finished only after this state saw its own tx_start;
  // that screens out the late byte_accepted of a previous frame's trailer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= 16'h0000;
      count_reg  <= 16'h0000;
      sample_reg <= '0;
      idx        <= '0;
      trailer    <= 8'h00;
      sent       <= 1'b0;
      rd_phase   <= 1'b0;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= sample_count;
            count_reg <= sample_count;
            underrun  <= 1'b0;
            busy      <= 1'b1;
            sent      <= 1'b0;
            state     <= HDR;
          end
        end
        HDR: begin
          if (tx_start) sent <= 1'b1;
          if (byte_accepted && sent) begin
            sent  <= 1'b0;
            state <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (tx_start) sent <= 1'b1;
          if (byte_accepted && sent) begin
            sent  <= 1'b0;
            state <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (tx_start) sent <= 1'b1;
          if (byte_accepted && sent) begin
            sent  <= 1'b0;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (remaining == 16'h0000) begin
            trailer <= TRL_OK;
            state   <= TRAIL;
          end else if (fifo_empty) begin
            underrun <= 1'b1;
            trailer  <= TRL_UNDER;
            state    <= TRAIL;
          end else begin
            fifo_rd_en <= 1'b1;
            remaining  <= remaining - 16'd1;
            rd_phase   <= 1'b0;
            state      <= WAIT_RD;
          end
        end
        // First cycle carries the pop strobe; the FIFO presents the word
        // in the second cycle, where it is captured.
        WAIT_RD: begin
          if (!rd_phase) begin
            rd_phase <= 1'b1;
          end else begin
            rd_phase   <= 1'b0;
            sample_reg <= SRW'(fifo_rd_data);
            idx        <= IW'(BPS - 1);
            sent       <= 1'b0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (tx_start) sent <= 1'b1;
          if (byte_accepted && sent) begin
            sent <= 1'b0;
            if (idx == '0) state <= FETCH;
            else           idx   <= idx - 1'b1;
          end
        end
        TRAIL: begin
          if (tx_start) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_readout.sv
module tb_capture_readout;
  import analyzer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT A: 8-bit samples ----------------
  logic        start = 1'b0;
  logic [15:0] sample_count = 16'h0000;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy, done, underrun;
  logic [3:0]  state_dbg;
  logic [1:0]  issuer_state_dbg;

  capture_readout #(.SAMPLE_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .sample_count(sample_count),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .done(done), .underrun(underrun),
    .state_dbg(state_dbg), .issuer_state_dbg(issuer_state_dbg)
  );

  // ---------------- DUT B: 12-bit samples ----------------
  logic        b_start = 1'b0;
  logic [15:0] b_count = 16'h0000;
  logic        b_empty;
  logic [11:0] b_rd_data;
  logic        b_rd_en;
  logic        b_tx_busy;
  logic        b_tx_start;
  logic [7:0]  b_tx_data;
  logic        b_busy, b_done, b_underrun;
  logic [3:0]  b_state;
  logic [1:0]  b_iss_state;

  capture_readout #(.SAMPLE_WIDTH(12)) dut_b (
    .clock(clock), .reset(reset), .start(b_start), .sample_count(b_count),
    .fifo_empty(b_empty), .fifo_rd_data(b_rd_data), .fifo_rd_en(b_rd_en),
    .tx_busy(b_tx_busy), .tx_start(b_tx_start), .tx_data(b_tx_data),
    .busy(b_busy), .done(b_done), .underrun(b_underrun),
    .state_dbg(b_state), .issuer_state_dbg(b_iss_state)
  );

  // ---------------- FIFO models (registered read) ----------------
  logic [7:0]  fifo_mem [16];
  int unsigned wptr = 0;
  int unsigned rptr;
  assign fifo_empty = (wptr == rptr);
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr <= 0;
      fifo_rd_data <= 8'h00;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= fifo_mem[rptr % 16];
      rptr <= rptr + 1;
    end
  end

  logic [11:0] b_mem = 12'h000;
  int unsigned b_wcnt = 0;
  int unsigned b_rcnt;
  assign b_empty = (b_wcnt == b_rcnt);
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      b_rcnt <= 0;
      b_rd_data <= 12'h000;
    end else if (b_rd_en) begin
      b_rd_data <= b_mem;
      b_rcnt <= b_rcnt + 1;
    end
  end

  // ---------------- UART models: 10 busy cycles per byte ----------------
  int bcnt, b_bcnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_busy <= 1'b0; bcnt <= 0;
    end else if (tx_start) begin
      tx_busy <= 1'b1; bcnt <= 9;
    end else if (bcnt != 0) bcnt <= bcnt - 1;
    else tx_busy <= 1'b0;
  end
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      b_tx_busy <= 1'b0; b_bcnt <= 0;
    end else if (b_tx_start) begin
      b_tx_busy <= 1'b1; b_bcnt <= 9;
    end else if (b_bcnt != 0) b_bcnt <= b_bcnt - 1;
    else b_tx_busy <= 1'b0;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_q_b[$];
  int rd_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (tx_start) begin
        check("a_tx_busy_at_start", tx_busy, 0);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL a_byte_extra: got %02h, expected no byte", tx_data);
        end else check("a_byte", tx_data, exp_q.pop_front());
      end
      if (fifo_rd_en) begin
        rd_cnt++;
        check("a_pop_when_empty", fifo_empty, 0);
      end
      if (done) done_cnt++;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (b_tx_start) begin
        check("b_tx_busy_at_start", b_tx_busy, 0);
        if (exp_q_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_byte_extra: got %02h, expected no byte", b_tx_data);
        end else check("b_byte", b_tx_data, exp_q_b.pop_front());
      end
      if (b_rd_en) check("b_pop_when_empty", b_empty, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input logic [7:0] v);
    fifo_mem[wptr % 16] = v;
    wptr++;
  endtask

  task automatic push_hdr(input logic [15:0] cnt);
    exp_q.push_back(8'hA5);
    exp_q.push_back(cnt[15:8]);
    exp_q.push_back(cnt[7:0]);
  endtask

  task automatic start_a(input logic [15:0] cnt, input bit chk);
    @(negedge clock);
    sample_count = cnt;
    start = 1'b1;
    @(posedge clock); #1;
    if (chk) begin
      check("start_latency_tx_start", tx_start, 1);
      check("start_busy", busy, 1);
      check("start_clears_underrun", underrun, 0);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done_a(input string name);
    for (int n = 0; n < 600; n++) begin
      @(negedge clock);
      if (done) break;
    end
    check(name, done, 1);
    repeat (15) @(negedge clock);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, state_dbg, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
  endtask

  // ---------------- sequence ----------------
  int rd0, d0;

  initial begin
    // reset state
    @(negedge clock);
    reset = 1'b1; wptr = 0; b_wcnt = 0;
    #1;
    check_idle_outputs("reset");
    check("reset_b_state", b_state, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // three samples, plus an ignored start mid-dump
    load(8'h11); load(8'h22); load(8'h33);
    push_hdr(16'd3);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(TRL_OK);
    rd0 = rd_cnt; d0 = done_cnt;
    start_a(16'd3, 1'b1);
    repeat (30) @(negedge clock);
    check("busy_mid_dump", busy, 1);
    start_a(16'd7, 1'b0);
    wait_done_a("s3_done");
    check("s3_pops", rd_cnt - rd0, 3);
    check("s3_done_pulses", done_cnt - d0, 1);
    check("s3_underrun", underrun, 0);
    check("s3_busy_after", busy, 0);
    check("s3_queue_drained", exp_q.size(), 0);

    // zero-length dump
    push_hdr(16'd0);
    exp_q.push_back(TRL_OK);
    rd0 = rd_cnt;
    start_a(16'd0, 1'b1);
    wait_done_a("s0_done");
    check("s0_pops", rd_cnt - rd0, 0);
    check("s0_underrun", underrun, 0);
    check("s0_queue_drained", exp_q.size(), 0);

    // underrun: two samples available, five requested
    load(8'h44); load(8'h55);
    push_hdr(16'd5);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    exp_q.push_back(TRL_UNDER);
    rd0 = rd_cnt;
    start_a(16'd5, 1'b1);
    wait_done_a("su_done");
    check("su_pops", rd_cnt - rd0, 2);
    check("su_underrun_set", underrun, 1);
    check("su_queue_drained", exp_q.size(), 0);
    repeat (5) @(negedge clock);
    check("su_underrun_sticky", underrun, 1);

    // reset while sending samples; the next start clears underrun
    load(8'h66); load(8'h77);
    push_hdr(16'd2);
    exp_q.push_back(8'h66); exp_q.push_back(8'h77);
    exp_q.push_back(TRL_OK);
    start_a(16'd2, 1'b1);
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if (state_dbg == 4'(SEND)) break;
    end
    check("sr_reach_send", state_dbg, SEND);
    #2;
    reset = 1'b1; wptr = 0;
    #1;
    check_idle_outputs("midreset");
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    load(8'h88);
    push_hdr(16'd1);
    exp_q.push_back(8'h88);
    exp_q.push_back(TRL_OK);
    rd0 = rd_cnt; d0 = done_cnt;
    start_a(16'd1, 1'b1);
    wait_done_a("sr_done");
    check("sr_pops", rd_cnt - rd0, 1);
    check("sr_done_pulses", done_cnt - d0, 1);
    check("sr_queue_drained", exp_q.size(), 0);

    // 12-bit sample: two bytes, MSB byte first
    b_mem = 12'hABC; b_wcnt = 1;
    exp_q_b.push_back(8'hA5); exp_q_b.push_back(8'h00); exp_q_b.push_back(8'h01);
    exp_q_b.push_back(8'h0A); exp_q_b.push_back(8'hBC);
    exp_q_b.push_back(TRL_OK);
    @(negedge clock);
    b_count = 16'd1; b_start = 1'b1;
    @(negedge clock);
    b_start = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clock);
      if (b_done) break;
    end
    check("b_done", b_done, 1);
    repeat (15) @(negedge clock);
    check("b_queue_drained", exp_q_b.size(), 0);
    check("b_underrun", b_underrun, 0);
    check("b_busy_after", b_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
